// File: rtl/forwarding_unit_param_if.sv
// Decode-side bus of the forwarding unit: operand requests, forwarded values,
// per-slot writeback data and the stall/statistics outputs.
interface forwarding_unit_param_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int CNTW  = 16
);
  logic                  flush;
  logic                  id_fw_valid;
  logic [AW-1:0]         id_fw_regdest;
  logic                  id_fw_writereg;
  logic                  id_fw_load;
  logic [NREAD*AW-1:0]   id_fw_addr;
  logic [NREAD*DW-1:0]   id_fw_regval;
  logic [NREAD*DW-1:0]   fw_id_regval;
  logic                  fw_if_id_stall;
  logic [DEPTH*DW-1:0]   st_fw_wbvalue;
  logic [DEPTH-1:0]      st_fw_writereg;
  logic [CNTW-1:0]       fw_stall_count;

  modport master (
    output flush, id_fw_valid, id_fw_regdest, id_fw_writereg, id_fw_load,
           id_fw_addr, id_fw_regval, st_fw_wbvalue, st_fw_writereg,
    input  fw_id_regval, fw_if_id_stall, fw_stall_count
  );

  modport slave (
    input  flush, id_fw_valid, id_fw_regdest, id_fw_writereg, id_fw_load,
           id_fw_addr, id_fw_regval, st_fw_wbvalue, st_fw_writereg,
    output fw_id_regval, fw_if_id_stall, fw_stall_count
  );
endinterface

// File: rtl/forwarding_unit_param.sv
// Operand forwarding and load-use hazard detection beside Decode: tracks the
// destinations of DEPTH in-flight instructions and picks the youngest producer.
module forwarding_unit_param #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16
) (
  input logic                    clock,
  input logic                    reset,
  forwarding_unit_param_if.slave bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]    v;
  logic [DEPTH-1:0]    ld;
  logic [AW-1:0]       dest [DEPTH];
  logic [CNTW-1:0]     count;
  logic [NREAD-1:0]    port_haz;
  logic [NREAD*DW-1:0] fwd_val;
  logic                stall;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0] addr;
    logic [DW-1:0] pass;
    logic [DW-1:0] sel;
    logic          haz;

    assign addr = bus.id_fw_addr[p*AW +: AW];
    assign pass = bus.id_fw_regval[p*DW +: DW];

    // Scan oldest to youngest so the youngest matching slot has the last word.
    always_comb begin
      sel = pass;
      haz = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v[k] && bus.st_fw_writereg[k] && (dest[k] == addr) && (addr != '0)) begin
          if (ld[k] && (k < LOAD_LAT)) begin
            sel = pass;
            haz = 1'b1;
          end else begin
            sel = bus.st_fw_wbvalue[k*DW +: DW];
            haz = 1'b0;
          end
        end
      end
    end

    assign port_haz[p]          = haz;
    assign fwd_val[p*DW +: DW]  = sel;
  end

  assign stall = bus.id_fw_valid & ~bus.flush & ~reset & (|port_haz);

  assign bus.fw_if_id_stall = stall;
  assign bus.fw_id_regval   = reset ? '0 : fwd_val;
  assign bus.fw_stall_count = count;

  // A stalled or flushed Decode instruction enters EX as a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        v[k]    <= v[k-1];
        ld[k]   <= ld[k-1];
        dest[k] <= dest[k-1];
      end
      v[0]    <= bus.id_fw_valid & bus.id_fw_writereg & ~stall & ~bus.flush;
      ld[0]   <= bus.id_fw_load;
      dest[0] <= bus.id_fw_regdest;
      if (stall && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
